dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_if.sv | 37 +++
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between an initiator (master) and dmem_responder (slave).
// req_be_i exists only when DMEM_BYTE_EN is defined.
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
`ifdef DMEM_BYTE_EN
  logic [BE_W-1:0]   req_be_i;
`endif
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_write_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
`ifdef DMEM_BYTE_EN
    output req_be_i,
`endif
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_write_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
`ifdef DMEM_BYTE_EN
    input  req_be_i,
`endif
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_write_o
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 64 storage: synchronous byte-strobed write, registered read.
// The read register clears on a store so store responses carry zero data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              access,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IdxW-1:0]   idx;
  logic [DATA_W-1:0] rdata_q;

  // Addresses beyond DEPTH wrap.
  assign idx = IdxW'({24'd0, addr} % DEPTH);

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (access && write) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (access) begin
      rdata_q <= write ? '0 : mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder with fixed LATENCY (1..7) from acceptance to response.
// Define DMEM_BYTE_EN to enable per-byte store strobes on req_be_i.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 256
) (
  input logic   clk_i,
  input logic   rst_ni,
  dmem_if.slave bus
);

  localparam logic [2:0] CntInit = 3'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rsp_write_q;

  logic              accept;
  logic              access;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic [BE_W-1:0]   req_be;

`ifdef DMEM_BYTE_EN
  assign req_be = bus.req_be_i;
`else
  assign req_be = '1;
`endif

  assign bus.req_ready_o = rst_ni && (state_q == IDLE);
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  // WAIT lasts LATENCY-1 cycles; the access happens on the edge that enters RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    access    = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            access    = 1'b1;
            acc_write = bus.req_write_i;
            acc_addr  = bus.req_addr_i;
            acc_wdata = bus.req_wdata_i;
            acc_be    = req_be;
            state_d   = RESP;
          end else begin
            cnt_d   = CntInit;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) rsp_write_q <= acc_write;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      write_q <= bus.req_write_i;
      addr_q  <= bus.req_addr_i;
      wdata_q <= bus.req_wdata_i;
      be_q    <= req_be;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .access (access),
    .write  (acc_write),
    .addr   (acc_addr),
    .wdata  (acc_wdata),
    .be     (acc_be),
    .rdata  (bus.rsp_rdata_o)
  );

  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_write_o = rsp_write_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2/DEPTH=256 and LATENCY=1/DEPTH=16 responders side by side.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [63:0] DataA = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] DataB = 64'hB0B0_B0B0_0505_0505;
  localparam logic [63:0] DataC = 64'hC0FF_EE00_1234_5678;
  localparam logic [63:0] Data20 = 64'h0000_0000_0000_5555;
`ifdef DMEM_BYTE_EN
  localparam logic [63:0] BeExp = 64'hFFFF_FFFF_0000_0000;
`else
  localparam logic [63:0] BeExp = 64'h0;
`endif

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rd;
    logic        exp_w;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_if bus2 ();
  dmem_if bus1 ();

  dmem_responder #(.LATENCY(2), .DEPTH(256)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));
  dmem_responder #(.LATENCY(1), .DEPTH(16))  dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 1) ? bus1.req_ready_o : bus2.req_ready_o;
  endfunction
  function automatic logic get_vld(input int sel);
    return (sel == 1) ? bus1.rsp_valid_o : bus2.rsp_valid_o;
  endfunction
  function automatic logic [63:0] get_rd(input int sel);
    return (sel == 1) ? bus1.rsp_rdata_o : bus2.rsp_rdata_o;
  endfunction
  function automatic logic get_w(input int sel);
    return (sel == 1) ? bus1.rsp_write_o : bus2.rsp_write_o;
  endfunction

  task automatic drive(input int sel, input logic v, input logic wr, input logic [7:0] a,
                       input logic [63:0] d, input logic [7:0] be);
    if (sel == 1) begin
      bus1.req_valid_i = v;
      bus1.req_write_i = wr;
      bus1.req_addr_i  = a;
      bus1.req_wdata_i = d;
`ifdef DMEM_BYTE_EN
      bus1.req_be_i    = be;
`endif
    end else begin
      bus2.req_valid_i = v;
      bus2.req_write_i = wr;
      bus2.req_addr_i  = a;
      bus2.req_wdata_i = d;
`ifdef DMEM_BYTE_EN
      bus2.req_be_i    = be;
`endif
    end
  endtask

  // One request with rsp_ready=1; lat counts edges from acceptance to first rsp_valid.
  task automatic txn(input int sel, input logic wr, input logic [7:0] a, input logic [63:0] d,
                     input logic [7:0] be, output logic [63:0] rd, output logic rw,
                     output int lat);
    int n;
    rd  = '0;
    rw  = 1'b0;
    lat = 0;
    if (sel == 1) bus1.rsp_ready_i = 1'b1;
    else          bus2.rsp_ready_i = 1'b1;
    @(negedge clk);
    drive(sel, 1'b1, wr, a, d, be);
    n = 0;
    while (!get_rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(get_rdy(sel)), 64'd1);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    lat = 1;
    while (!get_vld(sel) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = get_rd(sel);
    rw = get_w(sel);
    @(negedge clk);
  endtask

  vec_t        vecs[9];
  logic [63:0] rd;
  logic        rw;
  int          lat;
  int          n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'h10, DataA,                 8'hFF, 64'h0,                 1'b1};
    vecs[1] = '{1'b0, 8'h10, 64'h0,                 8'hFF, DataA,                 1'b0};
    vecs[2] = '{1'b1, 8'h30, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                 1'b1};
    vecs[3] = '{1'b1, 8'h30, 64'h0,                 8'h0F, 64'h0,                 1'b1};
    vecs[4] = '{1'b0, 8'h30, 64'h0,                 8'hFF, BeExp,                 1'b0};
    vecs[5] = '{1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,                 1'b1};
    vecs[6] = '{1'b0, 8'hFF, 64'h0,                 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[7] = '{1'b0, 8'h10, 64'h0,                 8'hFF, DataA,                 1'b0};
    vecs[8] = '{1'b1, 8'h20, Data20,                8'hFF, 64'h0,                 1'b1};

    drive(1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    bus1.rsp_ready_i = 1'b1;
    bus2.rsp_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus2.rsp_valid_o), 64'd0);
    check("rst_ready", 64'(bus2.req_ready_o), 64'd0);
    check("rst_rdata", bus2.rsp_rdata_o, 64'h0);
    check("rst_write", 64'(bus2.rsp_write_o), 64'd0);
    check("rst_ready_l1", 64'(bus1.req_ready_o), 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 64'(bus2.req_ready_o), 64'd1);

    for (int i = 0; i < 9; i++) begin
      txn(2, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, rw, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_write", i), 64'(rw), 64'(vecs[i].exp_w));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
    end

    // Response held with rsp_ready low; an extra store offered meanwhile must be ignored.
    @(negedge clk);
    bus2.rsp_ready_i = 1'b0;
    drive(2, 1'b1, 1'b0, 8'h10, 64'h0, 8'hFF);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 8'h10, 64'h1111_2222_3333_4444, 8'hFF);
    n = 0;
    while (!bus2.rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), 64'(bus2.rsp_valid_o), 64'd1);
      check($sformatf("hold%0d_rdata", i), bus2.rsp_rdata_o, DataA);
      check($sformatf("hold%0d_ready", i), 64'(bus2.req_ready_o), 64'd0);
      @(negedge clk);
    end
    drive(2, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    bus2.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("hold_release_ready", 64'(bus2.req_ready_o), 64'd1);
    check("hold_release_valid", 64'(bus2.rsp_valid_o), 64'd0);
    txn(2, 1'b0, 8'h10, 64'h0, 8'hFF, rd, rw, lat);
    check("ignored_store_rdata", rd, DataA);

    // Reset during WAIT aborts a store to 0x20.
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 8'h20, 64'h1, 8'hFF);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    check("abort_in_wait", 64'(bus2.req_ready_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_rst_valid", 64'(bus2.rsp_valid_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_no_rsp%0d", i), 64'(bus2.rsp_valid_o), 64'd0);
      @(negedge clk);
    end
    txn(2, 1'b0, 8'h20, 64'h0, 8'hFF, rd, rw, lat);
    check("abort_load_rdata", rd, Data20);

    // LATENCY=1, DEPTH=16: address wrap then back-to-back loads.
    txn(1, 1'b1, 8'h13, DataC, 8'hFF, rd, rw, lat);
    check("l1_store_latency", 64'(lat), 64'd1);
    check("l1_store_write", 64'(rw), 64'd1);
    txn(1, 1'b1, 8'h05, DataB, 8'hFF, rd, rw, lat);
    txn(1, 1'b0, 8'h03, 64'h0, 8'hFF, rd, rw, lat);
    check("l1_wrap_rdata", rd, DataC);
    check("l1_load_latency", 64'(lat), 64'd1);
    begin
      logic [7:0]  b2b_addr[3];
      logic [63:0] b2b_exp[3];
      int          issued;
      int          got;
      int          acc_cyc;
      int          last_rsp;
      b2b_addr = '{8'h03, 8'h05, 8'h13};
      b2b_exp  = '{DataC, DataB, DataC};
      issued   = 0;
      got      = 0;
      acc_cyc  = -10;
      last_rsp = -10;
      for (int c = 0; c < 30 && got < 3; c++) begin
        @(negedge clk);
        if (bus1.rsp_valid_o) begin
          check($sformatf("b2b%0d_latency", got), 64'(c - acc_cyc), 64'd1);
          check($sformatf("b2b%0d_rdata", got), bus1.rsp_rdata_o, b2b_exp[got]);
          if (got > 0) check($sformatf("b2b%0d_spacing", got), 64'(c - last_rsp), 64'd2);
          last_rsp = c;
          got++;
        end
        if (issued < 3) begin
          drive(1, 1'b1, 1'b0, b2b_addr[issued], 64'h0, 8'hFF);
          if (bus1.req_ready_o) begin
            acc_cyc = c;
            issued++;
          end
        end else begin
          drive(1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        end
      end
      drive(1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
      check("b2b_count", 64'(got), 64'd3);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
